lzc_norm_pipe: RTL and testbench

LZC_NORM_PIPE -- requirements
Module: lzc_norm_pipe

---
 rtl/lzc_norm_pipe.sv | 157 +++++++++++++++
 tb/tb_lzc_norm_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading/trailing bit counter with normaliser.
// Stage 1 captures the operand, its count mode, tag and a tree-built count;
// stage 2 captures the shifted operand, count, zero flag and tag.
// A valid/ready handshake sits on both sides, and there is no bubble
// between back-to-back operands.
module lzc_norm_pipe #(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 5,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int           LG   = $clog2(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  // Leading-zero count built as a balanced tree of pairwise merges.
  // Entry 0 of a group holds the MSB side. When the upper half of a pair
  // is all zeros, the pair count is the half size plus the lower count.
  function automatic logic [CW-1:0] lzc_tree(input logic [WIDTH-1:0] v);
    logic [CW-1:0] cnt [WIDTH];
    logic [CW-1:0] s;
    for (int i = 0; i < WIDTH; i++) begin
      cnt[i] = {{(CW-1){1'b0}}, ~v[WIDTH-1-i]};
    end
    s = {{(CW-1){1'b0}}, 1'b1};
    for (int lvl = 0; lvl < LG; lvl++) begin
      for (int g = 0; g < (WIDTH >> (lvl + 1)); g++) begin
        if (cnt[2*g] == s) cnt[g] = s + cnt[2*g+1];
        else               cnt[g] = cnt[2*g];
      end
      s = s << 1;
    end
    return cnt[0];
  endfunction

  logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] data_p1_q, data_p1_d, norm_p2_q, norm_p2_d;
  logic             trail_p1_q, trail_p1_d;
  logic [TAG_W-1:0] tag_p1_q, tag_p1_d, tag_p2_q, tag_p2_d;
  logic [CW-1:0]    cnt_p1_q, cnt_p1_d, cnt_p2_q, cnt_p2_d;
  logic             zero_p2_q, zero_p2_d;

  logic             ld_p1, ld_p2;
  logic             trail_s0;
  logic [WIDTH-1:0] scan_s0;
  logic [CW-1:0]    cnt_s0;
  logic             zero_s1;
  logic [WIDTH-1:0] norm_s1;

  // Pipeline advance: stage 2 moves when empty or drained, stage 1 follows.
  assign ld_p2    = !vld_p2_q || out_ready;
  assign ld_p1    = !vld_p1_q || ld_p2;
  assign in_ready = rst_n && ld_p1;

  // ---- stage 0 -> 1: map every mode onto a leading-zero scan and count ----
  always_comb begin
    trail_s0 = (in_mode == 2'b10);
    scan_s0  = in_data;
    if (in_mode == 2'b01) begin
      scan_s0 = ~in_data;
    end else if (trail_s0) begin
      for (int i = 0; i < WIDTH; i++) scan_s0[i] = in_data[WIDTH-1-i];
    end
    cnt_s0 = lzc_tree(scan_s0);
  end

  // Stage-1 next state: capture a new operand whenever stage 1 may load.
  always_comb begin
    vld_p1_d   = vld_p1_q;
    data_p1_d  = data_p1_q;
    trail_p1_d = trail_p1_q;
    tag_p1_d   = tag_p1_q;
    cnt_p1_d   = cnt_p1_q;
    if (ld_p1) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        data_p1_d  = in_data;
        trail_p1_d = trail_s0;
        tag_p1_d   = in_tag;
        cnt_p1_d   = cnt_s0;
      end
    end
  end

  // ---- stage 1 -> 2: normalise the operand by its count ----
  always_comb begin
    zero_s1 = (cnt_p1_q == FULL);
    if (zero_s1)         norm_s1 = data_p1_q;
    else if (trail_p1_q) norm_s1 = data_p1_q >> cnt_p1_q;
    else                 norm_s1 = data_p1_q << cnt_p1_q;
  end

  // Stage-2 next state: take stage 1 contents when stage 2 may load.
  always_comb begin
    vld_p2_d  = vld_p2_q;
    norm_p2_d = norm_p2_q;
    cnt_p2_d  = cnt_p2_q;
    zero_p2_d = zero_p2_q;
    tag_p2_d  = tag_p2_q;
    if (ld_p2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        norm_p2_d = norm_s1;
        cnt_p2_d  = cnt_p1_q;
        zero_p2_d = zero_s1;
        tag_p2_d  = tag_p1_q;
      end
    end
  end

  // State registers; reset empties the pipe and zeroes the visible result.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      data_p1_q  <= '0;
      trail_p1_q <= 1'b0;
      tag_p1_q   <= '0;
      cnt_p1_q   <= '0;
      vld_p2_q   <= 1'b0;
      norm_p2_q  <= '0;
      cnt_p2_q   <= '0;
      zero_p2_q  <= 1'b0;
      tag_p2_q   <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      data_p1_q  <= data_p1_d;
      trail_p1_q <= trail_p1_d;
      tag_p1_q   <= tag_p1_d;
      cnt_p1_q   <= cnt_p1_d;
      vld_p2_q   <= vld_p2_d;
      norm_p2_q  <= norm_p2_d;
      cnt_p2_q   <= cnt_p2_d;
      zero_p2_q  <= zero_p2_d;
      tag_p2_q   <= tag_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_count = cnt_p2_q;
  assign out_zero  = zero_p2_q;
  assign out_norm  = norm_p2_q;
  assign out_tag   = tag_p2_q;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Bench for lzc_norm_pipe: four instances (8/16/32/64 bits) share control
// and stimulus; results are scored against a bit-scanning reference model.
module tb_lzc_norm_pipe;

  typedef struct packed {
    logic [6:0]  cnt;
    logic        zero;
    logic [63:0] norm;
    logic [4:0]  tag;
  } exp_t;

  logic        CLK;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] din;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;

  logic        r8, r16, r32, r64, v8, v16, v32, v64, z8, z16, z32, z64;
  logic [3:0]  c8;
  logic [4:0]  c16;
  logic [5:0]  c32;
  logic [6:0]  c64;
  logic [7:0]  n8;
  logic [15:0] n16;
  logic [31:0] n32;
  logic [63:0] n64;
  logic [4:0]  t8, t16, t32, t64;

  logic        ordy [4];
  logic        ovld [4];
  logic        ozero [4];
  logic [6:0]  ocnt [4];
  logic [63:0] onorm [4];
  logic [4:0]  otag [4];

  int          checks;
  int          errors;
  int          wd [4] = '{8, 16, 32, 64};
  exp_t        q [4][$];
  logic [63:0] sd [$];
  logic [1:0]  sm [$];
  logic [4:0]  st [$];

  lzc_norm_pipe #(.WIDTH(8), .TAG_W(5)) u8 (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r8), .in_data(din[7:0]),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(v8), .out_ready(out_ready),
    .out_count(c8), .out_zero(z8), .out_norm(n8), .out_tag(t8));
  lzc_norm_pipe #(.WIDTH(16), .TAG_W(5)) u16 (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r16), .in_data(din[15:0]),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(v16), .out_ready(out_ready),
    .out_count(c16), .out_zero(z16), .out_norm(n16), .out_tag(t16));
  lzc_norm_pipe #(.WIDTH(32), .TAG_W(5)) u32 (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32), .in_data(din[31:0]),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
    .out_count(c32), .out_zero(z32), .out_norm(n32), .out_tag(t32));
  lzc_norm_pipe #(.WIDTH(64), .TAG_W(5)) u64 (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64), .in_data(din),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .out_count(c64), .out_zero(z64), .out_norm(n64), .out_tag(t64));

  assign ordy[0] = r8;  assign ordy[1] = r16;  assign ordy[2] = r32;  assign ordy[3] = r64;
  assign ovld[0] = v8;  assign ovld[1] = v16;  assign ovld[2] = v32;  assign ovld[3] = v64;
  assign ozero[0] = z8; assign ozero[1] = z16; assign ozero[2] = z32; assign ozero[3] = z64;
  assign ocnt[0] = 7'(c8);   assign ocnt[1] = 7'(c16);   assign ocnt[2] = 7'(c32);   assign ocnt[3] = c64;
  assign onorm[0] = 64'(n8); assign onorm[1] = 64'(n16); assign onorm[2] = 64'(n32); assign onorm[3] = n64;
  assign otag[0] = t8;  assign otag[1] = t16;  assign otag[2] = t32;  assign otag[3] = t64;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: scan bit by bit from the counting end until the terminator.
  function automatic exp_t ref_model(input logic [63:0] d, input int w,
                                     input logic [1:0] m, input logic [4:0] t);
    exp_t        r;
    logic [63:0] mask, v;
    int          n;
    bit          hit;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    v    = d & mask;
    n    = 0;
    hit  = 1'b0;
    for (int i = 0; i < w; i++) begin
      int   b;
      logic bv;
      b  = (m == 2'b10) ? i : (w - 1 - i);
      bv = v[b];
      if (!hit) begin
        if ((m == 2'b01) ? bv : !bv) n++;
        else hit = 1'b1;
      end
    end
    r.cnt  = 7'(n);
    r.zero = !hit;
    r.tag  = t;
    if (!hit)             r.norm = v;
    else if (m == 2'b10)  r.norm = v >> n;
    else                  r.norm = (v << n) & mask;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One operand into the idle pipe; the 32-bit result must appear exactly 2 edges later.
  task automatic directed(input logic [31:0] d, input logic [1:0] m, input logic [4:0] t,
                          input logic [6:0] ecnt, input logic ezero, input logic [31:0] enorm);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    din       = {32'h0, d};
    in_mode   = m;
    in_tag    = t;
    step();
    in_valid = 1'b0;
    chk("dir_valid_early", 64'(ovld[2]), 64'd0);
    step();
    chk("dir_valid", 64'(ovld[2]), 64'd1);
    chk("dir_count", 64'(ocnt[2]), 64'(ecnt));
    chk("dir_zero",  64'(ozero[2]), 64'(ezero));
    chk("dir_norm",  onorm[2], 64'(enorm));
    chk("dir_tag",   64'(otag[2]), 64'(t));
    step();
  endtask

  // Stream the queued stimulus with random back-pressure and score all widths.
  task automatic run_stream();
    int          idx, cyc;
    bit          prev_stall;
    logic [6:0]  pc;
    logic        pz;
    logic [63:0] pn;
    logic [4:0]  pt;
    exp_t        e;
    idx = 0; cyc = 0; prev_stall = 1'b0;
    pc = '0; pz = 1'b0; pn = '0; pt = '0;
    while ((idx < sd.size() || q[0].size() != 0 || q[1].size() != 0 ||
            q[2].size() != 0 || q[3].size() != 0) && cyc < 20000) begin
      if (prev_stall) begin
        chk("stall_valid", 64'(ovld[2]), 64'd1);
        chk("stall_count", 64'(ocnt[2]), 64'(pc));
        chk("stall_zero",  64'(ozero[2]), 64'(pz));
        chk("stall_norm",  onorm[2], pn);
        chk("stall_tag",   64'(otag[2]), 64'(pt));
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (idx < sd.size());
      if (in_valid) begin
        din     = sd[idx];
        in_mode = sm[idx];
        in_tag  = st[idx];
      end
      #1;
      chk("in_ready", 64'(ordy[2]), 64'(!(q[2].size() == 2 && !out_ready)));
      for (int k = 0; k < 4; k++) begin
        if (in_valid && ordy[k]) q[k].push_back(ref_model(din, wd[k], in_mode, in_tag));
        if (ovld[k] && out_ready) begin
          if (q[k].size() == 0) begin
            chk($sformatf("spurious_w%0d", wd[k]), 64'd1, 64'd0);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("count_w%0d", wd[k]), 64'(ocnt[k]), 64'(e.cnt));
            chk($sformatf("zero_w%0d", wd[k]),  64'(ozero[k]), 64'(e.zero));
            chk($sformatf("norm_w%0d", wd[k]),  onorm[k], e.norm);
            chk($sformatf("tag_w%0d", wd[k]),   64'(otag[k]), 64'(e.tag));
          end
        end
      end
      if (in_valid && ordy[2]) idx++;
      prev_stall = ovld[2] && !out_ready;
      pc = ocnt[2]; pz = ozero[2]; pn = onorm[2]; pt = otag[2];
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_timeout", 64'(cyc >= 20000), 64'd0);
    sd.delete(); sm.delete(); st.delete();
  endtask

  initial begin
    logic [63:0] r;
    int          w;
    logic [1:0]  m;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    in_mode   = '0;
    in_tag    = '0;

    // Reset state
    #1;
    chk("rst_valid", 64'(ovld[2]), 64'd0);
    chk("rst_ready", 64'(ordy[2]), 64'd0);
    chk("rst_count", 64'(ocnt[2]), 64'd0);
    chk("rst_norm",  onorm[2], 64'd0);
    chk("rst_tag",   64'(otag[2]), 64'd0);
    chk("rst_zero",  64'(ozero[2]), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(ordy[2]), 64'd1);

    // Directed 32-bit vectors
    directed(32'h0001_0000, 2'b00, 5'd3,  7'd15, 1'b0, 32'h8000_0000);
    directed(32'hFFFF_FFF0, 2'b01, 5'd4,  7'd28, 1'b0, 32'h0000_0000);
    directed(32'hFFFF_FFFF, 2'b01, 5'd5,  7'd32, 1'b1, 32'hFFFF_FFFF);
    directed(32'h0000_0A00, 2'b10, 5'd6,  7'd9,  1'b0, 32'h0000_0005);
    directed(32'h0000_0000, 2'b00, 5'd7,  7'd32, 1'b1, 32'h0000_0000);
    directed(32'h0001_0000, 2'b11, 5'd8,  7'd15, 1'b0, 32'h8000_0000);
    directed(32'h8000_0000, 2'b10, 5'd9,  7'd31, 1'b0, 32'h0000_0001);
    directed(32'h0000_0000, 2'b10, 5'd10, 7'd32, 1'b1, 32'h0000_0000);

    // Tags 0..7 back to back under random back-pressure
    for (int i = 0; i < 8; i++) begin
      sd.push_back({$urandom(), $urandom()} >> $urandom_range(0, 63));
      sm.push_back(2'($urandom_range(0, 2)));
      st.push_back(5'(i));
    end
    run_stream();

    // Reset with two operands in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din       = 64'h0000_0000_00F0_0000;
    in_mode   = 2'b00;
    in_tag    = 5'd17;
    step();
    din    = 64'h0000_0000_0000_0300;
    in_tag = 5'd18;
    step();
    in_valid = 1'b0;
    chk("inflight_valid", 64'(ovld[2]), 64'd1);
    chk("inflight_ready", 64'(ordy[2]), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(ovld[2]), 64'd0);
    chk("async_ready", 64'(ordy[2]), 64'd0);
    chk("async_tag",   64'(otag[2]), 64'd0);
    chk("async_count", 64'(ocnt[2]), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(ordy[2]), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_stale", 64'(ovld[2]), 64'd0);
    end

    // Single-bit operands at every position, all modes, then random operands
    for (int p = 0; p < 64; p++) begin
      for (int k = 0; k < 3; k++) begin
        sd.push_back(64'd1 << p);
        sm.push_back(2'(k));
        st.push_back(5'(p));
      end
    end
    for (int i = 0; i < 300; i++) begin
      w = wd[$urandom_range(0, 3)];
      m = 2'($urandom_range(0, 3));
      r = {$urandom(), $urandom()} >> (64 - w);
      r = r >> $urandom_range(0, w);
      if (m == 2'b01) r = ~r;
      if (m == 2'b10) r = {$urandom(), $urandom()} << $urandom_range(0, w);
      if (i % 50 == 0) r = '0;
      if (i % 50 == 1) r = {64{1'b1}};
      sd.push_back(r);
      sm.push_back(m);
      st.push_back(5'($urandom_range(0, 31)));
    end
    run_stream();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
